// File: rtl/fft_operand_fetch.sv
// fft_operand_fetch: strided pair-read sequencer in front of the FFT word RAM,
// buffering returned pairs in a credit-limited FIFO for the butterfly stream.
module fft_operand_fetch #(
    parameter int ADDR_WIDTH = 16,
    parameter int WORD_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [15:0]           pair_count_i,
    input  logic [ADDR_WIDTH-1:0] stride_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [31:0]           mem_data_a_i,
    input  logic [31:0]           mem_data_b_i,
    output logic                  pair_valid_o,
    input  logic                  pair_ready_i,
    output logic [WORD_WIDTH-1:0] pair_a_o,
    output logic [WORD_WIDTH-1:0] pair_b_o,
    output logic                  pair_last_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW+1:0] DEPTH_C = (PW+2)'(FIFO_DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [15:0]           count_q, count_d;
    logic [15:0]           issued_q, issued_d;
    logic                  inflight_q;
    logic                  infl_last_q;

    logic [WORD_WIDTH-1:0] fa_q [FIFO_DEPTH];
    logic [WORD_WIDTH-1:0] fb_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fl_q;
    logic [PW:0]           wr_q, rd_q;

    logic [PW:0]   occ_w;
    logic [PW+1:0] used_w;
    logic [PW-1:0] wr_idx, rd_idx;
    logic          credit_w, last_issue_w;
    logic          push_w, pop_w, full_w;
    logic          unused_w;

    assign occ_w        = wr_q - rd_q;
    assign full_w       = occ_w[PW];
    assign wr_idx       = wr_q[PW-1:0];
    assign rd_idx       = rd_q[PW-1:0];
    // Credit counts the read still in the RAM pipe so the FIFO never overflows.
    assign used_w       = {1'b0, occ_w} + (PW+2)'(inflight_q);
    assign credit_w     = used_w < DEPTH_C;
    assign last_issue_w = issued_q == (count_q - 16'd1);

    assign push_w       = inflight_q;
    assign pair_valid_o = wr_q != rd_q;
    assign pop_w        = pair_valid_o & pair_ready_i;

    assign pair_a_o     = fa_q[rd_idx];
    assign pair_b_o     = fb_q[rd_idx];
    assign pair_last_o  = pair_valid_o & fl_q[rd_idx];

    assign busy_o       = state_q != S_IDLE;
    assign mem_we_o     = 1'b0;
    assign mem_addr_o   = addr_q;
    assign unused_w     = ^{mem_data_a_i, mem_data_b_i};

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        stride_d = stride_q;
        count_d  = count_q;
        issued_d = issued_q;
        mem_en_o = 1'b0;
        done_o   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (pair_count_i != 16'd0) begin
                        addr_d   = base_addr_i;
                        stride_d = stride_i;
                        count_d  = pair_count_i;
                        issued_d = 16'd0;
                        state_d  = S_FETCH;
                    end else begin
                        state_d  = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                if (credit_w) begin
                    mem_en_o = 1'b1;
                    addr_d   = addr_q + stride_q;
                    issued_d = issued_q + 16'd1;
                    if (last_issue_w) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop_w && fl_q[rd_idx]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            stride_q    <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            fl_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fa_q[i] <= '0;
                fb_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            stride_q    <= stride_d;
            count_q     <= count_d;
            issued_q    <= issued_d;
            inflight_q  <= mem_en_o;
            infl_last_q <= mem_en_o & last_issue_w;
            if (push_w) begin
                fa_q[wr_idx] <= mem_data_a_i[WORD_WIDTH-1:0];
                fb_q[wr_idx] <= mem_data_b_i[WORD_WIDTH-1:0];
                fl_q[wr_idx] <= infl_last_q;
                wr_q         <= wr_q + PTR_ONE;
            end
            if (pop_w) begin
                rd_q <= rd_q + PTR_ONE;
            end
        end
    end

    assert property (@(posedge clk) disable iff (!rst)
        !(push_w && full_w && !pop_w));

endmodule

// File: tb/tb_fft_operand_fetch.sv
// Bench for fft_operand_fetch: randomized runs against a transaction-level
// model of issue credit, read latency and pair ordering.
module tb_fft_operand_fetch;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0;
    logic [15:0] base_addr_i = '0;
    logic [15:0] pair_count_i = '0;
    logic [15:0] stride_i = '0;
    logic        busy_o, done_o, mem_en_o, mem_we_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_data_a_i = '0;
    logic [31:0] mem_data_b_i = '0;
    logic        pair_valid_o;
    logic        pair_ready_i = 1'b0;
    logic [15:0] pair_a_o, pair_b_o;
    logic        pair_last_o;

    always #5 clk = ~clk;

    fft_operand_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .base_addr_i  (base_addr_i),
        .pair_count_i (pair_count_i),
        .stride_i     (stride_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .mem_en_o     (mem_en_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_a_i (mem_data_a_i),
        .mem_data_b_i (mem_data_b_i),
        .pair_valid_o (pair_valid_o),
        .pair_ready_i (pair_ready_i),
        .pair_a_o     (pair_a_o),
        .pair_b_o     (pair_b_o),
        .pair_last_o  (pair_last_o)
    );

    logic [15:0] ram [0:65535];
    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Model: run parameters plus issue/pop bookkeeping.
    bit          m_active = 0;
    int          m_cyc = 0;
    int          m_accept = -100;
    int          m_done_cyc = -1;
    int          m_cnt = 0;
    logic [15:0] m_base = '0;
    logic [15:0] m_stride = '0;
    int          m_issued = 0;
    int          m_popped = 0;
    int          issue_cyc[$];

    bit          pend = 0;
    logic [15:0] pend_addr = '0;

    int          obs_first_valid, obs_done, obs_done_n, obs_en, obs_busy;
    logic [15:0] obs_addr[$];
    logic [15:0] obs_pa[$];
    logic [15:0] obs_pb[$];
    bit          obs_pl[$];

    function automatic logic [15:0] pair_addr(int i);
        logic [15:0] ii;
        ii = 16'(i);
        return m_base + ii * m_stride;
    endfunction

    task automatic clear_obs();
        obs_first_valid = -1;
        obs_done = -1;
        obs_done_n = 0;
        obs_en = 0;
        obs_busy = 0;
        obs_addr.delete();
        obs_pa.delete();
        obs_pb.delete();
        obs_pl.delete();
    endtask

    // Single compare process: RAM response, model expectations and checks.
    always @(negedge clk) begin
        if (!rst) begin
            chk("rst_busy", busy_o, 0);
            chk("rst_done", done_o, 0);
            chk("rst_en", mem_en_o, 0);
            chk("rst_we", mem_we_o, 0);
            chk("rst_valid", pair_valid_o, 0);
            chk("rst_last", pair_last_o, 0);
            chk("rst_addr", mem_addr_o, 0);
            chk("rst_a", pair_a_o, 0);
            chk("rst_b", pair_b_o, 0);
            m_active = 0;
            m_done_cyc = -1;
            m_cnt = 0;
            m_issued = 0;
            m_popped = 0;
            issue_cyc.delete();
            pend = 0;
        end else begin
            int  avail;
            bit  e_en, e_valid, e_done;
            logic [15:0] ea;
            mem_data_a_i = $urandom;
            mem_data_b_i = $urandom;
            if (pend) begin
                mem_data_a_i[15:0] = ram[pend_addr];
                mem_data_b_i[15:0] = ram[pend_addr + 16'd1];
            end
            avail = 0;
            foreach (issue_cyc[i]) if (issue_cyc[i] <= m_cyc - 2) avail++;
            avail -= m_popped;
            e_en = m_active && m_cyc > m_accept && m_issued < m_cnt
                   && (m_issued - m_popped) < D;
            e_valid = avail > 0;
            e_done = m_cyc == m_done_cyc;
            chk("busy", busy_o, 32'(m_active));
            chk("done", done_o, 32'(e_done));
            chk("mem_en", mem_en_o, 32'(e_en));
            chk("mem_we", mem_we_o, 0);
            chk("valid", pair_valid_o, 32'(e_valid));
            if (e_en) chk("mem_addr", mem_addr_o, pair_addr(m_issued));
            if (e_valid) begin
                ea = pair_addr(m_popped);
                chk("pair_a", pair_a_o, ram[ea]);
                chk("pair_b", pair_b_o, ram[ea + 16'd1]);
                chk("pair_last", pair_last_o, 32'(m_popped == m_cnt - 1));
            end
            if (pair_valid_o && obs_first_valid < 0) obs_first_valid = m_cyc;
            if (done_o) begin
                obs_done = m_cyc;
                obs_done_n++;
            end
            if (busy_o) obs_busy++;
            if (mem_en_o) begin
                obs_en++;
                obs_addr.push_back(mem_addr_o);
            end
            if (pair_valid_o && pair_ready_i) begin
                obs_pa.push_back(pair_a_o);
                obs_pb.push_back(pair_b_o);
                obs_pl.push_back(pair_last_o);
            end
            pend = mem_en_o;
            pend_addr = mem_addr_o;
            if (e_en) begin
                issue_cyc.push_back(m_cyc);
                m_issued++;
            end
            if (e_valid && pair_ready_i) begin
                if (m_popped == m_cnt - 1) m_done_cyc = m_cyc + 1;
                m_popped++;
            end
            if (e_done) begin
                m_active = 0;
            end else if (!m_active && start_i) begin
                m_accept = m_cyc;
                m_active = 1;
                m_cnt = int'(pair_count_i);
                m_base = base_addr_i;
                m_stride = stride_i;
                m_issued = 0;
                m_popped = 0;
                issue_cyc.delete();
                if (m_cnt == 0) m_done_cyc = m_cyc + 1;
            end
            m_cyc++;
        end
    end

    int rdy_mode = 0;
    bit spur = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        start_i = 1'b0;
        case (rdy_mode)
            0: pair_ready_i = 1'b1;
            1: pair_ready_i = ($urandom_range(0, 3) != 0);
            default: pair_ready_i = 1'b0;
        endcase
        if (spur && m_active) begin
            start_i = 1'($urandom_range(0, 1));
            base_addr_i = 16'($urandom);
            pair_count_i = 16'($urandom_range(1, 20));
            stride_i = 16'($urandom);
        end
    endtask

    task automatic do_start(logic [15:0] b, logic [15:0] c,
                            logic [15:0] s);
        tick();
        start_i = 1'b1;
        base_addr_i = b;
        pair_count_i = c;
        stride_i = s;
    endtask

    task automatic wait_idle(int limit);
        int n;
        n = 0;
        tick();
        while (m_active && n < limit) begin
            tick();
            n++;
        end
        chk("run_timeout", 32'(n >= limit), 0);
    endtask

    initial begin
        foreach (ram[i]) ram[i] = 16'($urandom);
        for (int i = 0; i < 16; i++) ram[16'h0010 + 16'(i)] = 16'h1000 + 16'(i);
        clear_obs();
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        // Straight run, ready held high.
        clear_obs();
        rdy_mode = 0;
        do_start(16'h0010, 16'd4, 16'd2);
        wait_idle(200);
        chk("t1_first_valid_lat", 32'(obs_first_valid - m_accept), 3);
        chk("t1_done_lat", 32'(obs_done - m_accept), 7);
        chk("t1_npairs", 32'(obs_pa.size()), 4);
        if (obs_pa.size() == 4) begin
            chk("t1_a0", obs_pa[0], 16'h1000);
            chk("t1_b0", obs_pb[0], 16'h1001);
            chk("t1_a2", obs_pa[2], 16'h1004);
            chk("t1_b3", obs_pb[3], 16'h1007);
            chk("t1_last0", 32'(obs_pl[0]), 0);
            chk("t1_last3", 32'(obs_pl[3]), 1);
        end

        // Backpressure: ready low while the credit limit bites.
        clear_obs();
        rdy_mode = 2;
        do_start(16'h0010, 16'd8, 16'd2);
        repeat (12) tick();
        chk("t2_issue_stall", 32'(obs_en), 4);
        rdy_mode = 0;
        wait_idle(200);
        chk("t2_npairs", 32'(obs_pa.size()), 8);
        for (int k = 0; k < obs_pa.size(); k++)
            chk("t2_order", obs_pa[k], 16'h1000 + 16'(2 * k));

        // Zero-length run.
        clear_obs();
        do_start(16'h0055, 16'd0, 16'd3);
        wait_idle(50);
        chk("t3_no_en", 32'(obs_en), 0);
        chk("t3_done_lat", 32'(obs_done - m_accept), 1);
        chk("t3_busy_cycles", 32'(obs_busy), 1);

        // Address wrap at the top of the space.
        clear_obs();
        rdy_mode = 1;
        do_start(16'hFFFC, 16'd3, 16'd2);
        wait_idle(200);
        chk("t4_naddr", 32'(obs_addr.size()), 3);
        if (obs_addr.size() == 3) begin
            chk("t4_addr0", obs_addr[0], 16'hFFFC);
            chk("t4_addr1", obs_addr[1], 16'hFFFE);
            chk("t4_addr2", obs_addr[2], 16'h0000);
        end

        // Reset mid-run with two pairs buffered, then a fresh run.
        clear_obs();
        rdy_mode = 2;
        do_start(16'h0010, 16'd8, 16'd2);
        repeat (4) tick();
        rst = 1'b0;
        #1;
        chk("t5_valid_now", pair_valid_o, 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();
        chk("t5_no_done", 32'(obs_done_n), 0);
        clear_obs();
        rdy_mode = 1;
        do_start(16'h0040, 16'd5, 16'd3);
        wait_idle(300);
        chk("t5_npairs", 32'(obs_pa.size()), 5);
        chk("t5_one_done", 32'(obs_done_n), 1);

        // Start pulses during a run are ignored.
        clear_obs();
        spur = 1;
        do_start(16'h0100, 16'd6, 16'd5);
        wait_idle(300);
        spur = 0;
        chk("t6_npairs", 32'(obs_pa.size()), 6);
        chk("t6_one_done", 32'(obs_done_n), 1);

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            logic [15:0] s;
            s = (r % 5 == 0) ? 16'd0 : 16'($urandom);
            rdy_mode = $urandom_range(0, 1);
            spur = 1'($urandom_range(0, 1));
            clear_obs();
            do_start(16'($urandom), 16'($urandom_range(0, 12)), s);
            wait_idle(500);
            spur = 0;
            chk("rnd_npairs", 32'(obs_pa.size()), 32'(m_cnt));
        end
        rdy_mode = 1;
        clear_obs();
        do_start(16'hFFF0, 16'd40, 16'd1);
        wait_idle(1000);
        chk("long_npairs", 32'(obs_pa.size()), 40);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
